// File: rtl/seating_pkg.sv
// Shared widths, enums and request record for the seating front end.
package seating_pkg;

  localparam int STUDENT_W       = 32;
  localparam int SEAT_W          = 5;
  localparam int STATE_W         = 2;
  localparam int TIME_W          = 11;
  localparam int MINUTES_PER_DAY = 1440;

  typedef enum logic [STATE_W-1:0] {
    FREE     = 2'd0,
    AWAY     = 2'd1,
    OCCUPIED = 2'd2
  } seat_state_e;

  // seat_state is kept as raw bits so the illegal code 3 can be carried and rejected
  typedef struct packed {
    logic [STUDENT_W-1:0] student_no;
    logic [SEAT_W-1:0]    seat_no;
    logic [STATE_W-1:0]   seat_state;
  } seat_req_t;

  // Seat 0 does not exist and state code 3 is unassigned
  function automatic logic req_is_valid(input seat_req_t r);
    return (r.seat_no != '0) && (r.seat_state != 2'd3);
  endfunction

endpackage

// File: rtl/seat_req_fifo.sv
// Small synchronous FIFO of seat requests; pointers wrap naturally (DEPTH is a power of two).
module seat_req_fifo
  import seating_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  seat_req_t                    push_data,
  input  logic                         pop,
  output seat_req_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  seat_req_t        mem_q [DEPTH];

  // Next pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/seat_request_front.sv
// Kiosk-side front end: validates requests, buffers them, replays them as
// spaced write pulses and generates the minute-of-day Time bus.
module seat_request_front
  import seating_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int GAP           = 1,
  parameter int TICKS_PER_MIN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [STUDENT_W-1:0]         req_student_no,
  input  logic [SEAT_W-1:0]            req_seat_no,
  input  logic [STATE_W-1:0]           req_seat_state,
  output logic                         req_reject,
  output logic                         write,
  output logic [STUDENT_W-1:0]         Student_No,
  output logic [SEAT_W-1:0]            Seat_No,
  output logic [STATE_W-1:0]           Seat_State,
  output logic [TIME_W-1:0]            Time,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int GAP_W  = $clog2(GAP + 1);
  localparam int TICK_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } drain_state_e;

  seat_req_t        req_in;
  seat_req_t        head;
  logic [CNT_W-1:0] fifo_count;
  logic             accept;
  logic             push;
  logic             pop;

  drain_state_e     state_q;
  logic [GAP_W-1:0] gap_q;
  logic             write_q;
  seat_req_t        out_q;

  logic             reject_q, reject_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [TIME_W-1:0] time_q, time_d;

  assign req_in    = '{student_no: req_student_no, seat_no: req_seat_no, seat_state: req_seat_state};
  assign req_ready = !rst && (fifo_count < CNT_W'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign push      = accept && req_is_valid(req_in);
  // Pop decision uses registered occupancy, so a same-edge push never feeds a pop
  assign pop       = (state_q == S_IDLE) && (fifo_count != '0);

  seat_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (req_in),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  // Reject pulse for malformed transfers and free-running minute counter
  always_comb begin
    reject_d = accept && !req_is_valid(req_in);
    tick_d   = tick_q;
    time_d   = time_q;
    if (tick_q == TICK_W'(TICKS_PER_MIN - 1)) begin
      tick_d = '0;
      time_d = (time_q == TIME_W'(MINUTES_PER_DAY - 1)) ? '0 : time_q + TIME_W'(1);
    end else begin
      tick_d = tick_q + TICK_W'(1);
    end
  end

  // Registers for reject pulse and time base
  always_ff @(posedge clk) begin
    if (rst) begin
      reject_q <= 1'b0;
      tick_q   <= '0;
      time_q   <= '0;
    end else begin
      reject_q <= reject_d;
      tick_q   <= tick_d;
      time_q   <= time_d;
    end
  end

  // Drain FSM: one-cycle write per entry, then GAP hold cycles and one idle cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      write_q <= 1'b0;
      out_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            out_q   <= head;
            write_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          write_q <= 1'b0;
          gap_q   <= GAP_W'(GAP);
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          gap_q <= gap_q - GAP_W'(1);
          if (gap_q <= GAP_W'(1)) state_q <= S_IDLE;
        end
        default: begin
          write_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_reject = reject_q;
  assign write      = write_q;
  assign Student_No = out_q.student_no;
  assign Seat_No    = out_q.seat_no;
  assign Seat_State = out_q.seat_state;
  assign Time       = time_q;
  assign count      = fifo_count;

endmodule
